// File: rtl/seq_gen.sv
// seq_gen: latches a parallel pattern and sends it MSB-first on x, optionally repeated.
// Define SEQ_GEN_PARITY_EN to append one XOR parity bit after the final pass.
module seq_gen #(
    parameter int W  = 8,
    parameter int LW = 4,
    parameter int RW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [LW-1:0] length,
    input  logic [RW-1:0] repeats,
    output logic          x,
    output logic          x_valid,
    output logic          busy,
    output logic          done
);

`ifdef SEQ_GEN_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, PARITY = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

    localparam logic [LW-1:0] W_L = LW'(W);

    state_t        state_q, state_d;
    logic [W-1:0]  pat_q, pat_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [LW-1:0] len_eff;
    logic          x_q, x_d;
    logic          x_valid_q, x_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef SEQ_GEN_PARITY_EN
    logic          acc_q, acc_d;
`endif

    function automatic logic pick_bit(input logic [W-1:0] p, input logic [LW-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (idx == LW'(i)) b = p[i];
        end
        return b;
    endfunction

    assign len_eff = (length > W_L) ? W_L : length;

    // Outputs are registered, so they are derived from the next-state values.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
`ifdef SEQ_GEN_PARITY_EN
        acc_d     = acc_q;
`endif
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_eff != '0) begin
                        pat_d   = pattern;
                        len_d   = len_eff;
                        rep_d   = repeats;
                        idx_d   = len_eff - LW'(1);
`ifdef SEQ_GEN_PARITY_EN
                        acc_d   = 1'b0;
`endif
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
`ifdef SEQ_GEN_PARITY_EN
                acc_d = acc_q ^ pick_bit(pat_q, idx_q);
`endif
                if (idx_q != '0) begin
                    idx_d = idx_q - LW'(1);
                end else if (rep_q != '0) begin
                    rep_d = rep_q - RW'(1);
                    idx_d = len_q - LW'(1);
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            SHIFT: begin
                x_d       = pick_bit(pat_d, idx_d);
                x_valid_d = 1'b1;
                busy_d    = 1'b1;
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: begin
                x_d       = acc_d;
                x_valid_d = 1'b1;
                busy_d    = 1'b1;
            end
`endif
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
`ifdef SEQ_GEN_PARITY_EN
            acc_q     <= 1'b0;
`endif
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
`ifdef SEQ_GEN_PARITY_EN
            acc_q     <= acc_d;
`endif
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: randomized self-checking bench for seq_gen against a pass-by-pass bit-list model.
// Honours SEQ_GEN_PARITY_EN the same way the design does.
module tb_seq_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] length;
    logic [3:0] repeats;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle codes: 0 idle, 1 sending a 0, 2 sending a 1, 3 done pulse.
    logic [1:0] exp_q[$];

`ifdef SEQ_GEN_PARITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    always #5 clock = ~clock;

    seq_gen #(.W(8), .LW(4), .RW(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .length  (length),
        .repeats (repeats),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    // Reference: list every bit sent, pass by pass, then parity (if enabled), then the done pulse.
    function automatic void model_push(input logic [7:0] p, input int len, input int rep);
        int   eff;
        logic par;
        logic b;
        eff = (len > 8) ? 8 : len;
        par = 1'b0;
        for (int r = 0; r <= rep; r++) begin
            for (int i = eff - 1; i >= 0; i--) begin
                b   = ((p >> i) & 8'd1) != 8'd0;
                par = par ^ b;
                exp_q.push_back(b ? 2'd2 : 2'd1);
            end
        end
`ifdef SEQ_GEN_PARITY_EN
        if (eff != 0) exp_q.push_back(par ? 2'd2 : 2'd1);
`endif
        exp_q.push_back(2'd3);
    endfunction

    task automatic test_reset();
        reset   = 1'b0;
        start   = 1'b1;
        pattern = 8'($urandom());
        length  = 4'd8;
        repeats = 4'($urandom());
        for (int c = 1; c <= 2; c++) begin
            @(posedge clock); #1;
            checks++;
            if ({x, x_valid, busy, done} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got x/valid/busy/done=%b want 0000", c, {x, x_valid, busy, done});
            end
        end
        start = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({x, x_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_release: got x/valid/busy/done=%b want 0000", {x, x_valid, busy, done});
        end
    endtask

    // One transaction; inputs are scrambled after the latch to show they are ignored.
    task automatic test_transaction(input logic [7:0] p, input int len, input int rep, input string name);
        logic [1:0] code;
        logic       ev;
        logic       ex;
        exp_q.delete();
        model_push(p, len, rep);
        exp_q.push_back(2'd0);
        pattern = p;
        length  = len[3:0];
        repeats = rep[3:0];
        start   = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clock); #1;
            start   = 1'b0;
            pattern = 8'($urandom());
            length  = 4'($urandom());
            repeats = 4'($urandom());
            code = exp_q[k];
            ev   = (code == 2'd1) || (code == 2'd2);
            ex   = (code == 2'd2);
            checks++;
            if ({x_valid, x, busy, done} !== {ev, ex, ev, code == 2'd3}) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got valid/x/busy/done=%b want %b",
                         name, k + 1, {x_valid, x, busy, done}, {ev, ex, ev, code == 2'd3});
            end
        end
    endtask

    task automatic test_spec_vectors();
        logic [7:0] seq;
        logic       ev;
        logic       ex;
        logic       ed;
        seq     = 8'b1110_0110;
        pattern = seq;
        length  = 4'd8;
        repeats = 4'd0;
        start   = 1'b1;
        for (int c = 1; c <= 10 + EXTRA; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            ev = (c <= 8 + EXTRA);
            ex = (c <= 8) ? seq[8-c] : (c == 9 + EXTRA) ? 1'b0 : 1'b1;
            ed = (c == 9 + EXTRA);
            if (!ev) ex = 1'b0;
            checks++;
            if ({x_valid, x, busy, done} !== {ev, ex, ev, ed}) begin
                errors++;
                $display("[TB] FAIL literal_8bit cycle %0d: got valid/x/busy/done=%b want %b",
                         c, {x_valid, x, busy, done}, {ev, ex, ev, ed});
            end
        end
`ifdef SEQ_GEN_PARITY_EN
        begin
            logic [8:0] pexp;
            pexp    = 9'b1_0111_0110;
            pattern = 8'b0000_1011;
            length  = 4'd4;
            repeats = 4'd1;
            start   = 1'b1;
            for (int c = 1; c <= 11; c++) begin
                @(posedge clock); #1;
                start = 1'b0;
                ev = (c <= 9);
                ex = ev ? pexp[9-c] : 1'b0;
                ed = (c == 10);
                checks++;
                if ({x_valid, x, busy, done} !== {ev, ex, ev, ed}) begin
                    errors++;
                    $display("[TB] FAIL literal_parity cycle %0d: got valid/x/busy/done=%b want %b",
                             c, {x_valid, x, busy, done}, {ev, ex, ev, ed});
                end
            end
        end
`endif
        test_transaction(8'b0000_0111, 3, 2, "ones_x3");
        test_transaction(8'hA5, 0, 3, "len_zero");
        test_transaction(8'h5C, 12, 0, "len_clamp");
        test_transaction(8'h80, 1, 0, "len_one");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            test_transaction(8'($urandom()), $urandom_range(0, 12), $urandom_range(0, 3), "random");
        end
    endtask

    // Start held high: ignored in DONE, honoured in the following IDLE cycle.
    task automatic test_back_to_back();
        int         idle_idx;
        int         len;
        logic [1:0] code;
        logic       ev;
        logic       ex;
        len = $urandom_range(0, 9);
        exp_q.delete();
        pattern = 8'($urandom());
        length  = len[3:0];
        repeats = 4'($urandom_range(0, 1));
        model_push(pattern, len, int'(repeats));
        idle_idx = exp_q.size();
        exp_q.push_back(2'd0);
        model_push(pattern, len, int'(repeats));
        exp_q.push_back(2'd0);
        start = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clock); #1;
            if (k > idle_idx) start = 1'b0;
            code = exp_q[k];
            ev   = (code == 2'd1) || (code == 2'd2);
            ex   = (code == 2'd2);
            checks++;
            if ({x_valid, x, busy, done} !== {ev, ex, ev, code == 2'd3}) begin
                errors++;
                $display("[TB] FAIL back_to_back cycle %0d: got valid/x/busy/done=%b want %b",
                         k + 1, {x_valid, x, busy, done}, {ev, ex, ev, code == 2'd3});
            end
        end
        start = 1'b0;
    endtask

    task automatic test_midrun();
        logic [7:0] seq;
        logic [1:0] code;
        logic       ev;
        logic       ex;
        seq = 8'b1110_0110;
        exp_q.delete();
        model_push(seq, 8, 0);
        exp_q.push_back(2'd0);
        pattern = seq;
        length  = 4'd8;
        repeats = 4'd0;
        start   = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clock); #1;
            start = (k == 1 || k == 2);
            code = exp_q[k];
            ev   = (code == 2'd1) || (code == 2'd2);
            ex   = (code == 2'd2);
            checks++;
            if ({x_valid, x, busy, done} !== {ev, ex, ev, code == 2'd3}) begin
                errors++;
                $display("[TB] FAIL midrun_start cycle %0d: got valid/x/busy/done=%b want %b",
                         k + 1, {x_valid, x, busy, done}, {ev, ex, ev, code == 2'd3});
            end
        end
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            checks++;
            if ({x_valid, x, busy} !== {1'b1, seq[8-c], 1'b1}) begin
                errors++;
                $display("[TB] FAIL abort_prefix cycle %0d: got valid/x/busy=%b want %b",
                         c, {x_valid, x, busy}, {1'b1, seq[8-c], 1'b1});
            end
        end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        checks++;
        if ({x, x_valid, busy, done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL abort_reset: got x/valid/busy/done=%b want 0000", {x, x_valid, busy, done});
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            checks++;
            if ({x_valid, busy, done} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL abort_quiet cycle %0d: got valid/busy/done=%b want 000", c, {x_valid, busy, done});
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        pattern = '0;
        length  = '0;
        repeats = '0;
        test_reset();
        test_spec_vectors();
        test_random();
        test_back_to_back();
        test_back_to_back();
        test_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
